// File: rtl/spi_reg_bank_if.sv
// SPI pad bundle between an SPI controller and the register-bank peripheral.
// Latency: none, wires only.
// Backpressure: none; SPI mode 0 has no flow control, the controller owns pacing.
// Signals: sclk/copi/ncs driven by master (async pads), cipo driven by slave.
interface spi_reg_bank_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (output sclk, output copi, output ncs, input cipo);
    modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-frame decoder into 5 x 8-bit PWM control registers.
// Latency: register visible <= SYNC_STAGES+2 clk after the ncs pad rises.
// Backpressure: none; frames are consumed at pad rate, invalid frames dropped silently.
// Ports: clk, rst_n (sync, active-low); spi (slave modport: sclk/copi/ncs in, cipo out);
//        en_reg_out_7_0/15_8, en_reg_pwm_7_0/15_8, pwm_duty_cycle (regs 0x00..0x04);
//        wr_strobe/wr_addr (1-clk pulse and address of each committed write).
// Optional feature macro: SPI_READBACK_EN (read frames shift register data out on cipo).
module spi_reg_bank #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_reg_bank_if.slave       spi,
    output logic [7:0]          en_reg_out_7_0,
    output logic [7:0]          en_reg_out_15_8,
    output logic [7:0]          en_reg_pwm_7_0,
    output logic [7:0]          en_reg_pwm_15_8,
    output logic [7:0]          pwm_duty_cycle,
    output logic                wr_strobe,
    output logic [6:0]          wr_addr
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_d, ncs_d;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_rise;

    state_t      state_q, state_d;
    logic        start, shift_en, commit;
    logic [15:0] shift_q;
    logic [4:0]  cnt_q;
    logic        wr_ok;

    // Pad synchronizers, reset to the idle bus levels so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
            sclk_d    <= sclk_s;
            ncs_d     <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // IDLE starts on the synced ncs level rather than the edge: a short ncs glitch
    // can fall again while COMMIT is active, and that restart must not be lost.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!ncs_s) begin
                    state_d = ST_SHIFT;
                    start   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise) state_d = ST_COMMIT;
                else if (sclk_rise && !ncs_s) shift_en = 1'b1;
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_ok = (cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q         <= '0;
            cnt_q           <= '0;
            wr_strobe       <= 1'b0;
            wr_addr         <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (start) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (shift_en) begin
                shift_q <= {shift_q[14:0], copi_s};
                // Saturate at 17 so any overlong frame stays distinguishable from 16.
                if (cnt_q != 5'd17) cnt_q <= cnt_q + 5'd1;
            end
            if (commit && wr_ok) begin
                wr_strobe <= 1'b1;
                wr_addr   <= shift_q[14:8];
                case (shift_q[14:8])
                    7'h00:   en_reg_out_7_0  <= shift_q[7:0];
                    7'h01:   en_reg_out_15_8 <= shift_q[7:0];
                    7'h02:   en_reg_pwm_7_0  <= shift_q[7:0];
                    7'h03:   en_reg_pwm_15_8 <= shift_q[7:0];
                    7'h04:   pwm_duty_cycle  <= shift_q[7:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [6:0] rd_addr;
    logic [7:0] rd_val;
    logic [7:0] rd_sh;
    logic [3:0] rd_left;
    logic       cipo_q;

    assign sclk_fall = ~sclk_s & sclk_d;
    // Address as it stands once the 8th bit lands this cycle.
    assign rd_addr   = {shift_q[5:0], copi_s};

    always_comb begin
        rd_val = 8'h00;
        if (rd_addr <= MAX_ADDR) begin
            case (rd_addr)
                7'h00:   rd_val = en_reg_out_7_0;
                7'h01:   rd_val = en_reg_out_15_8;
                7'h02:   rd_val = en_reg_pwm_7_0;
                7'h03:   rd_val = en_reg_pwm_15_8;
                7'h04:   rd_val = pwm_duty_cycle;
                default: rd_val = 8'h00;
            endcase
        end
    end

    // shift_q[6] holds the R/W bit when the 8th bit is being shifted in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_sh   <= '0;
            rd_left <= '0;
            cipo_q  <= 1'b0;
        end else if (ncs_s || commit) begin
            rd_left <= '0;
            cipo_q  <= 1'b0;
        end else if (shift_en && cnt_q == 5'd7 && !shift_q[6]) begin
            rd_sh   <= rd_val;
            rd_left <= 4'd8;
        end else if (sclk_fall && rd_left != 4'd0) begin
            cipo_q  <= rd_sh[7];
            rd_sh   <= {rd_sh[6:0], 1'b0};
            rd_left <= rd_left - 4'd1;
        end
    end

    assign spi.cipo = cipo_q;
`else
    assign spi.cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: 10 MHz clk, 100 kHz sclk, 5 us ncs setup/hold.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_spi_reg_bank;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [39:0] dut_bank;

    spi_reg_bank_if spi();

    spi_reg_bank dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spi),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe),
        .wr_addr         (wr_addr)
    );

    assign dut_bank = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         strobe_cnt = 0;
    int         exp_strobe_cnt = 0;
    logic [7:0] exp_regs [5];
    wr_t        exp_q [$];

    function automatic logic [39:0] exp_bank();
        return {exp_regs[4], exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
    endfunction

    function automatic logic [7:0] reg_at(input logic [6:0] a);
        case (a)
            7'h00:   return en_reg_out_7_0;
            7'h01:   return en_reg_out_15_8;
            7'h02:   return en_reg_pwm_7_0;
            7'h03:   return en_reg_pwm_15_8;
            7'h04:   return pwm_duty_cycle;
            default: return 8'hxx;
        endcase
    endfunction

    function automatic logic [7:0] exp_read(input logic [6:0] a);
`ifdef SPI_READBACK_EN
        return (a <= 7'h04) ? exp_regs[a[2:0]] : 8'h00;
`else
        return 8'h00;
`endif
    endfunction

    // Scoreboard consumer: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            wr_t e;
            strobe_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_strobe: got addr=%0h data=%0h, expected no write", wr_addr, reg_at(wr_addr));
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, reg_at(wr_addr)} !== {e.addr, e.data})
                    $display("FAIL strobe_write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             wr_addr, reg_at(wr_addr), e.addr, e.data);
                else
                    n_pass++;
            end
        end
    end

    // Drives one frame of nbits; bits past 16 are zeros. Valid writes are pushed to the
    // scoreboard as they are driven. reset_mid pulses rst_n before ncs is released.
    task automatic send_frame(input logic [15:0] word, input int nbits, input bit reset_mid,
                              output logic [7:0] rd_byte);
        rd_byte = 8'h00;
        if (!reset_mid && nbits == 16 && word[15] && word[14:8] <= 7'h04) begin
            exp_q.push_back('{addr: word[14:8], data: word[7:0]});
            exp_regs[word[10:8]] = word[7:0];
            exp_strobe_cnt++;
        end
        @(negedge clk);
        spi.ncs = 1'b0;
        repeat (50) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi.copi = (i < 16) ? word[15 - i] : 1'b0;
            repeat (50) @(negedge clk);
            if (i >= 8 && i < 16) rd_byte = {rd_byte[6:0], spi.cipo};
            spi.sclk = 1'b1;
            repeat (50) @(negedge clk);
            spi.sclk = 1'b0;
        end
        if (reset_mid) begin
            rst_n = 1'b0;
            repeat (5) @(negedge clk);
            rst_n = 1'b1;
            for (int r = 0; r < 5; r++) exp_regs[r] = 8'h00;
            exp_q.delete();
        end
        repeat (50) @(negedge clk);
        spi.ncs  = 1'b1;
        spi.copi = 1'b0;
        // SYNC_STAGES+2 clk edges after ncs rises the write must be visible.
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        spi.ncs  = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        for (int r = 0; r < 5; r++) exp_regs[r] = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_bank !== 40'h0) $display("FAIL reset_regs: got %h, expected 0", dut_bank); else n_pass++;
        n_checks++;
        if (wr_strobe !== 1'b0) $display("FAIL reset_strobe: got %b, expected 0", wr_strobe); else n_pass++;
        n_checks++;
        if (wr_addr !== 7'h00) $display("FAIL reset_addr: got %h, expected 0", wr_addr); else n_pass++;
        n_checks++;
        if (spi.cipo !== 1'b0) $display("FAIL reset_cipo: got %b, expected 0", spi.cipo); else n_pass++;
    endtask

    task automatic test_write_basic();
        logic [7:0] rd;
        send_frame(16'h80F0, 16, 1'b0, rd);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL write0_latency: %0d writes pending, expected 0", exp_q.size()); else n_pass++;
        n_checks++;
        if (dut_bank !== exp_bank()) $display("FAIL write0_regs: got %h, expected %h", dut_bank, exp_bank()); else n_pass++;
        n_checks++;
        if (strobe_cnt != exp_strobe_cnt) $display("FAIL write0_strobes: got %0d, expected %0d", strobe_cnt, exp_strobe_cnt); else n_pass++;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_bad_addr();
        logic [7:0] rd;
        send_frame(16'h8480, 16, 1'b0, rd);
        n_checks++;
        if (dut_bank !== exp_bank()) $display("FAIL duty_regs: got %h, expected %h", dut_bank, exp_bank()); else n_pass++;
        repeat (50) @(negedge clk);
        send_frame(16'h85AA, 16, 1'b0, rd);
        n_checks++;
        if (dut_bank !== exp_bank()) $display("FAIL badaddr_regs: got %h, expected %h", dut_bank, exp_bank()); else n_pass++;
        n_checks++;
        if (strobe_cnt != exp_strobe_cnt) $display("FAIL badaddr_strobes: got %0d, expected %0d", strobe_cnt, exp_strobe_cnt); else n_pass++;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_short_overrun();
        logic [7:0] rd;
        send_frame(16'h82A0, 12, 1'b0, rd);
        n_checks++;
        if (dut_bank !== exp_bank()) $display("FAIL short_regs: got %h, expected %h", dut_bank, exp_bank()); else n_pass++;
        repeat (50) @(negedge clk);
        send_frame(16'h8255, 17, 1'b0, rd);
        n_checks++;
        if (dut_bank !== exp_bank()) $display("FAIL overrun_regs: got %h, expected %h", dut_bank, exp_bank()); else n_pass++;
        n_checks++;
        if (strobe_cnt != exp_strobe_cnt) $display("FAIL overrun_strobes: got %0d, expected %0d", strobe_cnt, exp_strobe_cnt); else n_pass++;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_read_no_write();
        logic [7:0] rd, exp_rd;
        send_frame(16'h81FF, 16, 1'b0, rd);
        repeat (50) @(negedge clk);
        exp_rd = exp_read(7'h01);
        send_frame(16'h0100, 16, 1'b0, rd);
        n_checks++;
        if (rd !== exp_rd) $display("FAIL read1_cipo: got %h, expected %h", rd, exp_rd); else n_pass++;
        n_checks++;
        if (dut_bank !== exp_bank()) $display("FAIL read1_regs: got %h, expected %h", dut_bank, exp_bank()); else n_pass++;
        n_checks++;
        if (strobe_cnt != exp_strobe_cnt) $display("FAIL read1_strobes: got %0d, expected %0d", strobe_cnt, exp_strobe_cnt); else n_pass++;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rd;
        send_frame(16'h835A, 9, 1'b1, rd);
        n_checks++;
        if (dut_bank !== 40'h0) $display("FAIL midreset_regs: got %h, expected 0", dut_bank); else n_pass++;
        repeat (50) @(negedge clk);
        send_frame(16'h835A, 16, 1'b0, rd);
        n_checks++;
        if (dut_bank !== exp_bank()) $display("FAIL postreset_regs: got %h, expected %h", dut_bank, exp_bank()); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL postreset_latency: %0d writes pending, expected 0", exp_q.size()); else n_pass++;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_readback();
        logic [7:0] rd, exp_rd;
        send_frame(16'h80F0, 16, 1'b0, rd);
        repeat (50) @(negedge clk);
        exp_rd = exp_read(7'h00);
        send_frame(16'h0000, 16, 1'b0, rd);
        n_checks++;
        if (rd !== exp_rd) $display("FAIL read0_cipo: got %h, expected %h", rd, exp_rd); else n_pass++;
        repeat (50) @(negedge clk);
        exp_rd = exp_read(7'h7F);
        send_frame(16'h7F00, 16, 1'b0, rd);
        n_checks++;
        if (rd !== exp_rd) $display("FAIL read7f_cipo: got %h, expected %h", rd, exp_rd); else n_pass++;
        n_checks++;
        if (spi.cipo !== 1'b0) $display("FAIL idle_cipo: got %b, expected 0", spi.cipo); else n_pass++;
        n_checks++;
        if (dut_bank !== exp_bank()) $display("FAIL readback_regs: got %h, expected %h", dut_bank, exp_bank()); else n_pass++;
        n_checks++;
        if (strobe_cnt != exp_strobe_cnt) $display("FAIL readback_strobes: got %0d, expected %0d", strobe_cnt, exp_strobe_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_bad_addr();
        test_short_overrun();
        test_read_no_write();
        test_reset_mid_frame();
        test_readback();
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
